// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY-side responder: 32x16 register file, PHY ID at regs 2/3, self-clearing reg 0 bit 15.
// Optional macro MDIO_BROADCAST_EN: also accept write frames addressed to PHYAD 0.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [31:0] PHY_ID       = 32'h0022_1622,
  parameter int          PREAMBLE_LEN = 32
) (
  input  logic        clk125,
  input  logic        reset,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic [15:0] ctrl_reg,
  output logic        wr_valid,
  output logic [4:0]  wr_reg,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  localparam logic [3:0] S_PREAMBLE = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_OPCODE   = 4'd2;
  localparam logic [3:0] S_PHYAD    = 4'd3;
  localparam logic [3:0] S_REGAD    = 4'd4;
  localparam logic [3:0] S_TA       = 4'd5;
  localparam logic [3:0] S_WR_DATA  = 4'd6;
  localparam logic [3:0] S_RD_DATA  = 4'd7;
  localparam logic [3:0] S_SKIP     = 4'd8;

  localparam logic [5:0] PRE_LEN = 6'(PREAMBLE_LEN);
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b01;

  logic        mdc_p0, mdc_p1, mdc_prev;
  logic        mdio_p0, mdio_p1;
  logic        bit_evt;
  logic [3:0]  state;
  logic [5:0]  ones_cnt;
  logic [4:0]  bit_cnt;
  logic [1:0]  op;
  logic [4:0]  phyad;
  logic [4:0]  regad;
  logic        ta_first;
  logic [15:0] shift;
  logic [15:0] regs [32];
  logic [15:0] rd_val;
  logic [15:0] wr_word;
  logic        wr_fire;
  logic        addr_match;

  // Stage 0/1: two-flop synchronizers, then MDC rising-edge detect
  always_ff @(posedge clk125) begin
    if (reset) begin
      mdc_p0   <= 1'b0;
      mdc_p1   <= 1'b0;
      mdc_prev <= 1'b0;
      mdio_p0  <= 1'b1;
      mdio_p1  <= 1'b1;
    end else begin
      mdc_p0   <= mdc_i;
      mdc_p1   <= mdc_p0;
      mdc_prev <= mdc_p1;
      mdio_p0  <= mdio_i;
      mdio_p1  <= mdio_p0;
    end
  end

  assign bit_evt = mdc_p1 & ~mdc_prev;

  always_comb begin
    addr_match = (phyad == PHY_ADDR);
`ifdef MDIO_BROADCAST_EN
    if (op == OP_WR && phyad == 5'd0) addr_match = 1'b1;
`endif
  end

  always_comb begin
    rd_val = regs[regad];
    if (regad == 5'd2) rd_val = PHY_ID[31:16];
    if (regad == 5'd3) rd_val = PHY_ID[15:0];
  end

  assign wr_word = {shift[14:0], mdio_p1};
  assign wr_fire = bit_evt && (state == S_WR_DATA) && (bit_cnt == 5'd15);

  // Stage 2: frame decoder, acting once per bit event
  always_ff @(posedge clk125) begin
    if (reset) begin
      state     <= S_PREAMBLE;
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      mdio_t    <= 1'b1;
      mdio_o    <= 1'b0;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (bit_evt) begin
        case (state)
          S_PREAMBLE: begin
            if (mdio_p1) begin
              if (ones_cnt < PRE_LEN) ones_cnt <= ones_cnt + 6'd1;
            end else if (ones_cnt >= PRE_LEN) begin
              state    <= S_START;
              ones_cnt <= '0;
            end else begin
              ones_cnt <= '0;
            end
          end
          S_START: begin
            bit_cnt <= '0;
            if (mdio_p1) begin
              state <= S_OPCODE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_PREAMBLE;
              ones_cnt  <= '0;
            end
          end
          S_OPCODE: begin
            op <= {op[0], mdio_p1};
            if (bit_cnt == 5'd1) begin
              if (op[0] == mdio_p1) begin
                // Bad opcode: drop the remaining PHYAD+REGAD+TA+DATA bits
                frame_err <= 1'b1;
                state     <= S_SKIP;
                bit_cnt   <= 5'd27;
              end else begin
                state   <= S_PHYAD;
                bit_cnt <= '0;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_PHYAD: begin
            phyad <= {phyad[3:0], mdio_p1};
            if (bit_cnt == 5'd4) begin
              state   <= S_REGAD;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_REGAD: begin
            regad <= {regad[3:0], mdio_p1};
            if (bit_cnt == 5'd4) begin
              state   <= addr_match ? S_TA : S_SKIP;
              bit_cnt <= addr_match ? 5'd0 : 5'd17;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_TA: begin
            if (bit_cnt == 5'd0) begin
              ta_first <= mdio_p1;
              bit_cnt  <= 5'd1;
              if (op == OP_RD) begin
                mdio_t <= 1'b0;
                mdio_o <= 1'b0;
              end
            end else if (op == OP_RD) begin
              mdio_o  <= rd_val[15];
              shift   <= {rd_val[14:0], 1'b0};
              state   <= S_RD_DATA;
              bit_cnt <= '0;
            end else if ({ta_first, mdio_p1} == 2'b10) begin
              state   <= S_WR_DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_SKIP;
              bit_cnt   <= 5'd15;
            end
          end
          S_RD_DATA: begin
            if (bit_cnt == 5'd15) begin
              mdio_t   <= 1'b1;
              mdio_o   <= 1'b0;
              state    <= S_PREAMBLE;
              ones_cnt <= '0;
            end else begin
              mdio_o  <= shift[15];
              shift   <= {shift[14:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_WR_DATA: begin
            shift <= wr_word;
            if (bit_cnt == 5'd15) begin
              wr_valid <= 1'b1;
              wr_reg   <= regad;
              wr_data  <= wr_word;
              state    <= S_PREAMBLE;
              ones_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_SKIP: begin
            if (bit_cnt == 5'd0) begin
              state    <= S_PREAMBLE;
              ones_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
            end
          end
          default: begin
            state    <= S_PREAMBLE;
            ones_cnt <= '0;
            mdio_t   <= 1'b1;
          end
        endcase
      end
    end
  end

  // Register file; reg 0 bit 15 is cleared the cycle after any write sets it
  always_ff @(posedge clk125) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      regs[0][15] <= 1'b0;
      if (wr_fire && regad != 5'd2 && regad != 5'd3) regs[regad] <= wr_word;
    end
  end

  assign ctrl_reg = regs[0];

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: bit-banged Clause 22 frames with hand-computed expectations.
module tb_mdio_phy_responder;

  logic        clk125 = 1'b0;
  logic        reset  = 1'b1;
  logic        mdc_i  = 1'b0;
  logic        mdio_i = 1'b1;
  logic        mdio_o, mdio_t, wr_valid, frame_err;
  logic [15:0] ctrl_reg, wr_data;
  logic [4:0]  wr_reg;

  int n_checks = 0;
  int n_fail   = 0;

  int          wr_cnt = 0, ferr_cnt = 0, tlow_cnt = 0;
  logic [4:0]  last_reg;
  logic [15:0] last_data, ctrl_at_wr, ctrl_after;
  logic        wr_d = 1'b0;

  mdio_phy_responder dut (
    .clk125(clk125), .reset(reset), .mdc_i(mdc_i), .mdio_i(mdio_i),
    .mdio_o(mdio_o), .mdio_t(mdio_t), .ctrl_reg(ctrl_reg),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data), .frame_err(frame_err)
  );

  always #4 clk125 = ~clk125;

  always @(negedge clk125) begin
    if (wr_d) ctrl_after = ctrl_reg;
    wr_d = wr_valid;
    if (wr_valid) begin
      wr_cnt++;
      last_reg   = wr_reg;
      last_data  = wr_data;
      ctrl_at_wr = ctrl_reg;
    end
    if (frame_err) ferr_cnt++;
    if (!mdio_t) tlow_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One MDC period of 16 clk125 cycles; s is MDIO as seen just before the rising edge
  task automatic mdc_bit(input logic b, output logic s);
    @(negedge clk125);
    mdio_i = b;
    repeat (7) @(negedge clk125);
    s = mdio_o;
    mdc_i = 1'b1;
    repeat (8) @(negedge clk125);
    mdc_i = 1'b0;
  endtask

  task automatic send_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                            input logic [15:0] data, input int abort_at, output logic [15:0] rd);
    logic [31:0] body;
    logic b, s;
    body = {st, op, phy, ra, ta, data};
    rd = '0;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, s);
    for (int i = 0; i < 32; i++) begin
      if (i == abort_at) return;
      b = body[31-i];
      if (op == 2'b10 && i >= 14) b = 1'b1;
      mdc_bit(b, s);
      if (i >= 16) rd = {rd[14:0], s};
    end
    mdio_i = 1'b1;
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk125);
    n_checks++; if (mdio_t !== 1'b1) begin n_fail++; $display("FAIL rst_mdio_t: got %b want 1", mdio_t); end
    n_checks++; if (mdio_o !== 1'b0) begin n_fail++; $display("FAIL rst_mdio_o: got %b want 0", mdio_o); end
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wr_valid: got %b want 0", wr_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    n_checks++; if (ctrl_reg !== 16'h0000) begin n_fail++; $display("FAIL rst_ctrl_reg: got %h want 0000", ctrl_reg); end
    reset = 1'b0;
    repeat (4) @(negedge clk125);
  endtask

  task automatic test_write_read();
    int w0, t0;
    logic [15:0] rd;
    w0 = wr_cnt;
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'd4, 2'b10, 16'hA5C3, 99, rd);
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL wr_pulses: got %0d want 1", wr_cnt - w0); end
    n_checks++; if (last_reg !== 5'd4) begin n_fail++; $display("FAIL wr_reg: got %0d want 4", last_reg); end
    n_checks++; if (last_data !== 16'hA5C3) begin n_fail++; $display("FAIL wr_data: got %h want a5c3", last_data); end
    t0 = tlow_cnt;
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, 99, rd);
    repeat (4) @(negedge clk125);
    n_checks++; if (rd !== 16'hA5C3) begin n_fail++; $display("FAIL rd_reg4: got %h want a5c3", rd); end
    n_checks++; if (tlow_cnt - t0 !== 17 * 16) begin n_fail++; $display("FAIL drive_window: got %0d cycles want 272", tlow_cnt - t0); end
    n_checks++; if (mdio_t !== 1'b1) begin n_fail++; $display("FAIL release_after_rd: got %b want 1", mdio_t); end
  endtask

  task automatic test_phy_id();
    int w0;
    logic [15:0] rd;
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0000, 99, rd);
    n_checks++; if (rd !== 16'h0022) begin n_fail++; $display("FAIL id_reg2: got %h want 0022", rd); end
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, 99, rd);
    n_checks++; if (rd !== 16'h1622) begin n_fail++; $display("FAIL id_reg3: got %h want 1622", rd); end
    w0 = wr_cnt;
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'hFFFF, 99, rd);
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL id_wr_pulse: got %0d want 1", wr_cnt - w0); end
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, 99, rd);
    n_checks++; if (rd !== 16'h1622) begin n_fail++; $display("FAIL id_reg3_after_wr: got %h want 1622", rd); end
  endtask

  task automatic test_preamble();
    int w0, f0, t0;
    logic [15:0] rd;
    w0 = wr_cnt; f0 = ferr_cnt; t0 = tlow_cnt;
    send_frame(31, 2'b01, 2'b01, 5'd1, 5'd4, 2'b10, 16'h0000, 99, rd);
    n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL short_pre_wr: got %0d want 0", wr_cnt - w0); end
    n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL short_pre_ferr: got %0d want 0", ferr_cnt - f0); end
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, 99, rd);
    n_checks++; if (rd !== 16'hA5C3) begin n_fail++; $display("FAIL short_pre_kept: got %h want a5c3", rd); end
    f0 = ferr_cnt; t0 = tlow_cnt;
    send_frame(32, 2'b00, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, 99, rd);
    n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL st00_ferr: got %0d want 1", ferr_cnt - f0); end
    n_checks++; if (tlow_cnt - t0 !== 0) begin n_fail++; $display("FAIL st00_drive: got %0d want 0", tlow_cnt - t0); end
  endtask

  task automatic test_address();
    int w0, t0;
    logic [15:0] rd;
    w0 = wr_cnt; t0 = tlow_cnt;
    send_frame(32, 2'b01, 2'b01, 5'd7, 5'd4, 2'b10, 16'h1111, 99, rd);
    send_frame(32, 2'b01, 2'b10, 5'd0, 5'd4, 2'b11, 16'h0000, 99, rd);
    n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL phy7_wr: got %0d want 0", wr_cnt - w0); end
    n_checks++; if (tlow_cnt - t0 !== 0) begin n_fail++; $display("FAIL foreign_drive: got %0d want 0", tlow_cnt - t0); end
    w0 = wr_cnt;
    send_frame(32, 2'b01, 2'b01, 5'd0, 5'd5, 2'b10, 16'h1234, 99, rd);
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd5, 2'b11, 16'h0000, 99, rd);
`ifdef MDIO_BROADCAST_EN
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL bcast_wr: got %0d want 1", wr_cnt - w0); end
    n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL bcast_rd: got %h want 1234", rd); end
`else
    n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL phy0_wr: got %0d want 0", wr_cnt - w0); end
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL phy0_rd: got %h want 0000", rd); end
`endif
  endtask

  task automatic test_ta_error();
    int w0, f0;
    logic [15:0] rd;
    w0 = wr_cnt; f0 = ferr_cnt;
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'd6, 2'b11, 16'h5555, 99, rd);
    n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ta_ferr: got %0d want 1", ferr_cnt - f0); end
    n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL ta_wr: got %0d want 0", wr_cnt - w0); end
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd6, 2'b11, 16'h0000, 99, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL ta_reg6: got %h want 0000", rd); end
  endtask

  task automatic test_ctrl_selfclear();
    logic [15:0] rd;
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h8140, 99, rd);
    repeat (2) @(negedge clk125);
    n_checks++; if (ctrl_at_wr !== 16'h8140) begin n_fail++; $display("FAIL ctrl_wr_cycle: got %h want 8140", ctrl_at_wr); end
    n_checks++; if (ctrl_after !== 16'h0140) begin n_fail++; $display("FAIL ctrl_next_cycle: got %h want 0140", ctrl_after); end
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd0, 2'b11, 16'h0000, 99, rd);
    n_checks++; if (rd !== 16'h0140) begin n_fail++; $display("FAIL ctrl_readback: got %h want 0140", rd); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rd;
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, 24, rd);
    n_checks++; if (mdio_t !== 1'b0) begin n_fail++; $display("FAIL mid_driving: got %b want 0", mdio_t); end
    reset = 1'b1;
    @(posedge clk125); #1;
    n_checks++; if (mdio_t !== 1'b1) begin n_fail++; $display("FAIL mid_release: got %b want 1", mdio_t); end
    repeat (3) @(negedge clk125);
    n_checks++; if (ctrl_reg !== 16'h0000) begin n_fail++; $display("FAIL mid_ctrl_clear: got %h want 0000", ctrl_reg); end
    reset = 1'b0;
    repeat (3) @(negedge clk125);
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, 99, rd);
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL mid_reg4_clear: got %h want 0000", rd); end
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'd9, 2'b10, 16'hBEEF, 99, rd);
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd9, 2'b11, 16'h0000, 99, rd);
    n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL mid_next_frame: got %h want beef", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_phy_id();
    test_preamble();
    test_address();
    test_ta_error();
    test_ctrl_selfclear();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_phy_responder.md
MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: PHY address this block answers to.
REQ-002 SHALL have parameter PHY_ID, default 32'h0022_1622: value returned for reg 2 (bits 31:16) and reg 3 (bits 15:0).
REQ-003 SHALL have parameter PREAMBLE_LEN, default 32, legal range 1..32: minimum number of consecutive 1 bits before a start.
REQ-004 SHALL have port clk125  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mdc_i  input  1  MDC from the station, asynchronous to clk125.
REQ-007 SHALL have port mdio_i  input  1  MDIO pad input, asynchronous.
REQ-008 SHALL have port mdio_o  output  1  MDIO drive value.
REQ-009 SHALL have port mdio_t  output  1  tristate enable; 1 = released (input), 0 = driving mdio_o.
REQ-010 SHALL have port ctrl_reg  output  16  current contents of reg 0.
REQ-011 SHALL have port wr_valid  output  1  one-cycle pulse per accepted write.
REQ-012 SHALL have port wr_reg  output  5  register address of the accepted write; valid with wr_valid.
REQ-013 SHALL have port wr_data  output  16  data of the accepted write; valid with wr_valid.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on a malformed frame.

Function
REQ-015 SHALL pass mdc_i and mdio_i through two-flop synchronizers, detect an MDC rising edge as sync=1 with previous sync=0, and sample MDIO only on that detected edge ("bit event").
REQ-016 SHALL implement Clause 22 frames: PRE, ST=01, OP (10 read, 01 write), PHYAD[4:0] MSB first, REGAD[4:0] MSB first, TA (2 bits), DATA[15:0] MSB first.
REQ-017 SHALL use the states PREAMBLE, START, OPCODE, PHYAD, REGAD, TA, WR_DATA, RD_DATA and SKIP.
REQ-018 In PREAMBLE, each 1 SHALL increment a ones counter that saturates at PREAMBLE_LEN; a 0 with counter >= PREAMBLE_LEN SHALL enter START; a 0 with counter < PREAMBLE_LEN SHALL clear the counter.
REQ-019 In START, a 1 SHALL enter OPCODE; a 0 SHALL pulse frame_err and return to PREAMBLE with the counter cleared.
REQ-020 OP 00 or 11 SHALL pulse frame_err and enter SKIP.
REQ-021 When PHYAD does not match PHY_ADDR, the block SHALL enter SKIP after REGAD; SKIP SHALL consume the remaining 18 bit events with mdio_t=1, then return to PREAMBLE.
REQ-022 For a matched read, mdio_t SHALL go 0 with mdio_o=0 in the clk125 cycle after the bit event of the first TA bit.
REQ-023 After each following bit event, the block SHALL drive the next data bit, D15 first; D15 SHALL follow the second TA bit event.
REQ-024 After the bit event on which the master samples D0, the block SHALL set mdio_t=1 and return to PREAMBLE.
REQ-025 Read data SHALL be latched at the second TA bit event.
REQ-026 For a matched write, TA SHALL be 10; any other TA value SHALL pulse frame_err and enter SKIP without a write.
REQ-027 On a matched write, after the 16th data bit event, the register SHALL update and wr_valid/wr_reg/wr_data SHALL pulse in the same cycle.
REQ-028 Register file: 32 x 16 bits, all reset to 0; reads of regs 2 and 3 SHALL return PHY_ID; writes to regs 2 and 3 SHALL be ignored for storage but SHALL still pulse wr_valid.
REQ-029 Reg 0 bit 15 SHALL be self-clearing: when written as 1, it SHALL read 1 in the cycle of the write and 0 from the next clk125 cycle.
REQ-030 mdio_t SHALL be 0 only during a matched read, from TA bit 2 through D0.

Reset
REQ-031 While reset=1, the block SHALL hold: state=PREAMBLE, counter=0, mdio_t=1, mdio_o=0, wr_valid=0, frame_err=0, and all registers=0 (ctrl_reg=0).
REQ-032 A reset asserted mid-frame SHALL release MDIO (mdio_t=1) on the next clk125 edge and discard the frame.

Configuration
REQ-033 Macro MDIO_BROADCAST_EN, when defined, SHALL make write frames with PHYAD=0 accepted as if matched; reads to PHYAD=0 SHALL still be treated per REQ-021 unless PHY_ADDR=0.
REQ-034 With MDIO_BROADCAST_EN undefined, only PHYAD=PHY_ADDR SHALL be accepted.

Verification
REQ-035 Bench: 32 ones, then write PHYAD=1, REGAD=4, data 16'hA5C3 -> one wr_valid pulse with wr_reg=4, wr_data=A5C3; a subsequent read of reg 4 returns A5C3 with mdio_t=0 for exactly 17 bit periods.
REQ-036 Bench: read reg 2, then reg 3 -> 16'h0022, then 16'h1622; a write of 16'hFFFF to reg 3 -> wr_valid pulses, read still returns 16'h1622.
REQ-037 Bench: 31 ones then start (PREAMBLE_LEN=32) -> no response, no frame_err; ST=00 after a valid preamble -> frame_err pulse.
REQ-038 Bench: write PHYAD=7 -> no wr_valid and mdio_t=1 throughout; with MDIO_BROADCAST_EN, a write to PHYAD=0, reg 5, 16'h1234 -> wr_valid pulses, and reg 5 reads back 1234.
REQ-039 Bench: write 16'h8140 to reg 0 -> ctrl_reg=8140 for one cycle, then 0140.
REQ-040 Bench: assert reset at data bit 8 of a read -> mdio_t=1 on the next clk125 edge, all registers 0; the next good frame is decoded correctly.
